// File: rtl/uart_pkg.sv
// uart_pkg: shared UART byte width, ASCII case constants and echo FSM states
package uart_pkg;
  localparam int UART_BYTE_W = 8;
  localparam logic [UART_BYTE_W-1:0] ASCII_LC_A = 8'h61;
  localparam logic [UART_BYTE_W-1:0] ASCII_LC_Z = 8'h7A;
  localparam logic [UART_BYTE_W-1:0] ASCII_CASE_OFS = 8'h20;
  typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT_HI, WAIT_LO} echo_state_t;
  function automatic logic [UART_BYTE_W-1:0] upcase(input logic [UART_BYTE_W-1:0] b);
    return (b >= ASCII_LC_A && b <= ASCII_LC_Z) ? b - ASCII_CASE_OFS : b;
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: register-array FIFO; a push into a full FIFO succeeds only alongside a pop
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CAP = (AW+1)'(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic do_push, do_pop;
  assign full = count == CAP;
  assign empty = count == '0;
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout = mem[rptr];
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop) rptr <= rptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end
endmodule

// File: rtl/uart_echo_resp.sv
// uart_echo_resp: buffers bytes from uart_rx and retransmits each one through uart_tx
module uart_echo_resp
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter bit UPCASE = 0,
  parameter int BUSY_WAIT = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [UART_BYTE_W-1:0]     rx_data,
  input  logic                       rx_ready,
  input  logic                       tx_busy,
  output logic [UART_BYTE_W-1:0]     tx_data,
  output logic                       tx_send,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       overflow
);
  localparam int CW = $clog2(BUSY_WAIT) + 1;
  echo_state_t state;
  logic [CW-1:0] wait_cnt;
  logic [UART_BYTE_W-1:0] din, dout;
  logic full, empty, pop;
  assign din = UPCASE ? upcase(rx_data) : rx_data;
  assign pop = state == LOAD;
  sync_fifo #(.WIDTH(UART_BYTE_W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(rx_ready),
    .pop(pop),
    .din(din),
    .dout(dout),
    .count(fifo_count),
    .full(full),
    .empty(empty)
  );
  // a tx that never raises busy within the window is taken as already finished
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      tx_data <= '0;
      tx_send <= 1'b0;
      overflow <= 1'b0;
      wait_cnt <= '0;
    end else begin
      tx_send <= state == LOAD;
      if (rx_ready && full && !pop) overflow <= 1'b1;
      case (state)
        IDLE: if (!empty && !tx_busy) state <= LOAD;
        LOAD: begin
          tx_data <= dout;
          state <= SEND;
        end
        SEND: begin
          wait_cnt <= '0;
          state <= WAIT_HI;
        end
        WAIT_HI: begin
          if (tx_busy) state <= WAIT_LO;
          else if (wait_cnt == CW'(BUSY_WAIT - 1)) state <= IDLE;
          else wait_cnt <= wait_cnt + CW'(1);
        end
        WAIT_LO: if (!tx_busy) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/uart_echo_resp.md
Name: uart_echo_resp

Overview:
- Far-end responder for the UART link: consumes bytes reported by uart_rx, buffers them, and retransmits each one through uart_tx.
- Turns the existing TX→RX loopback into a round-trip echo, so a host-side initiator can send a string and check the same string comes back.
- Sits between uart_rx (data_out/ready) and uart_tx (data_in/send/busy). Shares the baud_gen tick domain only indirectly, through those blocks.

Parameters:
- DEPTH, 16, echo FIFO depth in bytes; must be a power of two, ≥2.
- UPCASE, 0, when 1 converts ASCII 'a'..'z' (0x61..0x7A) to upper case before buffering; all other bytes pass unchanged.
- BUSY_WAIT, 8, clk cycles allowed for tx_busy to rise after a send pulse before the byte is treated as sent.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- rx_data  in  8  byte from uart_rx data_out; valid only while rx_ready=1
- rx_ready  in  1  uart_rx ready strobe; one accepted byte per cycle it is high
- tx_busy  in  1  uart_tx busy
- tx_data  out  8  byte to uart_tx data_in; held stable from send through completion
- tx_send  out  1  single-cycle send pulse to uart_tx
- fifo_count  out  $clog2(DEPTH)+1  bytes currently buffered
- overflow  out  1  sticky; set when a byte is dropped because the FIFO is full

Behaviour:
- Reset (synchronous, on clk rising edge with reset=1):
  - tx_data=0, tx_send=0, fifo_count=0, overflow=0.
  - FIFO pointers cleared, FSM returns to IDLE.
  - Any in-flight byte is abandoned; uart_tx is reset by the same signal.
- Write side:
  - Every cycle with rx_ready=1 pushes (UPCASE ? upcase(rx_data) : rx_data).
  - If full and no pop occurs in the same cycle: the byte is dropped, overflow←1, and overflow stays set until reset.
  - If full and a pop occurs in the same cycle: the push succeeds and count is unchanged.
  - Push and pop in the same cycle on a non-empty FIFO: both happen, count unchanged.
  - Push into an empty FIFO: the byte becomes visible to the FSM the next cycle, so no same-cycle bypass.
- FIFO storage:
  - Register array, wptr/rptr of $clog2(DEPTH) bits, wrapping naturally at DEPTH.
  - fifo_count updates on the same edge as push/pop.
- FSM states: IDLE, LOAD, SEND, WAIT_HI, WAIT_LO.
  - IDLE: if fifo_count≠0 and tx_busy=0 → LOAD.
  - LOAD: pop the head into tx_data → SEND.
  - SEND: tx_send=1 for exactly this one cycle → WAIT_HI, and the BUSY_WAIT counter is cleared.
  - WAIT_HI: on tx_busy=1 → WAIT_LO. If the counter reaches BUSY_WAIT-1 with tx_busy still 0 → IDLE (byte counts as sent; covers a tx that finished within the window).
  - WAIT_LO: on tx_busy=0 → IDLE.
- Latency: from the rx_ready cycle to tx_send high is 3 clk when the FSM is IDLE and tx is idle (push, IDLE→LOAD, LOAD→SEND).
- tx_send is never asserted while tx_busy=1. Back-to-back bytes therefore cost at least 2 idle clk between busy falling and the next send.
- tx_data changes only in LOAD.
- Order is preserved strictly FIFO; no byte is duplicated.
- rx_ready held high for N cycles counts as N pushes (uart_rx contract is a 1-cycle strobe).

Decomposition:
- Shared package uart_pkg holds:
  - UART_BYTE_W=8
  - ASCII_LC_A=8'h61, ASCII_LC_Z=8'h7A, ASCII_CASE_OFS=8'h20
  - FSM state encoding for echo_state_t
- One natural sub-module: sync_fifo (parameters WIDTH, DEPTH; ports push, pop, din, dout, count, full, empty). It is reusable for a later buffered-TX block. uart_echo_resp instantiates it and adds the FSM and upcase logic.

Test Plan:
- Loopback round-trip: bench uart_tx → uart_rx → uart_echo_resp → uart_tx2 → uart_rx2, with baud_gen CLK_FREQ=100_000, BAUD_RATE=9600. Send "VARTEX" → uart_rx2 reports 0x56,0x41,0x52,0x54,0x45,0x58 in order, overflow=0.
- UPCASE=1: send 'v','a','1' → echoed 0x56,0x41,0x31.
- Latency: with tx idle, a single rx_ready pulse with rx_data=0x5A → tx_send high exactly 3 clk later with tx_data=0x5A held until tx_busy falls.
- Overflow (DEPTH=4, tx_busy forced 1): push 0x10..0x15 → fifo_count=4, overflow=1. Release busy → only 0x10..0x13 are sent.
- Simultaneous push/pop when full: force a pop cycle concurrent with rx_ready=1, data 0x99 → count stays 4, overflow stays 0, 0x99 is sent last.
- Busy timeout and reset mid-operation:
  - tx_busy tied 0: each byte produces one tx_send, then IDLE after BUSY_WAIT cycles.
  - Assert reset during WAIT_LO with 3 bytes queued → next cycle all outputs are 0, the FSM is IDLE, and no further tx_send occurs.
